win_checker: RTL and testbench
==============================

# win_checker

Game logic unit for the Connect Four board. While the game FSM holds `logic_go` high in its check-winner state, this block reads all seven columns of the on/off and player boards, scans every four-in-a-row window, and returns `logic_result` (UNSURE / OVER / NOTOVER). It sits directly downstream of the game FSM and the board RAMs. At the top level, `rd_addr` is muxed onto the board address whenever `logic_go` is high.

## Interface
- `COLS`, 7, board columns (fixed; RAM address range 0..6)
- `ROWS`, 6, board rows (column word width)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `logic_go`  in  1  level request from the game FSM; must stay high until a non-UNSURE result is seen
- `cur_player`  in  1  player who just moved; sampled on start
- `rd_onoff`  in  6  on/off board column word; bit r = row r, row 0 = bottom; 1 = occupied
- `rd_player`  in  6  player board column word; bit r = owner of row r
- `rd_addr`  out  3  column read address
- `logic_result`  out  2  0 = UNSURE, 1 = OVER, 2 = NOTOVER; 3 is never driven
- `winner`  out  1  winning player; valid when result is OVER and `is_draw` = 0
- `is_draw`  out  1  board full with no four-in-a-row
- `busy`  out  1  high in LOAD and SCAN states

## Operation
- Board RAMs have a 1-cycle synchronous read: the address issued in cycle k returns data in cycle k+1.
- A cell belongs to player p when onoff = 1 and player = p.
- States:
  - IDLE: `logic_result` = UNSURE. When `logic_go` = 1, latch `cur_player`, clear `cnt`, and go to LOAD.
  - LOAD (8 cycles, `cnt` 0..7): `rd_addr` = `cnt` for `cnt` ≤ 6, else 0. When `cnt` ≥ 1, capture {`rd_onoff`, `rd_player`} into shadow column `cnt`-1. After `cnt` = 7, go to SCAN_H.
  - SCAN_H: check 24 horizontal windows.
  - SCAN_V: check 21 vertical windows.
  - SCAN_D1: check 12 up-right diagonal windows.
  - SCAN_D2: check 12 down-right diagonal windows.
  - Each SCAN state takes one cycle.
- Any window match: register OVER, set `winner`, and go to DONE immediately (early exit).
- SCAN_D2 with no match:
  - All 42 onoff bits set: OVER, `is_draw` = 1, `winner` = 0.
  - Otherwise: NOTOVER.
- DONE: hold `logic_result`, `winner`, and `is_draw` while `logic_go` = 1. When `logic_go` = 0, go to IDLE and clear all three.
- `logic_go` falling in LOAD or SCAN: abort to IDLE on the next edge. The result stays UNSURE and the shadow contents are discarded.
- Reset, including mid-operation: asynchronous return to IDLE.
  - Outputs: `rd_addr` = 0, `logic_result` = 0, `winner` = 0, `is_draw` = 0, `busy` = 0.
  - Internal state: shadow board and latched player cleared.
- Shadow board is 84 flops. No arithmetic beyond the 3-bit `cnt`.

## Timing
- E0 is the edge that samples `logic_go` = 1 in IDLE.
- LOAD occupies the cycles after E0..E7, with captures at E1..E8.
- `logic_result` becomes non-UNSURE after the edge leaving the deciding SCAN state:
  - Horizontal win: after E9.
  - Vertical win: after E10.
  - D1 win: after E11.
  - D2 win, draw, or NOTOVER: after E12.
- Worst-case latency is 12 cycles from E0.
- `logic_result` returns to UNSURE one cycle after `logic_go` drops.
- A new request needs at least one IDLE cycle after DONE.
- All outputs are registered. `rd_addr` changes only on clock edges.

## Configuration
- `WIN_CHECK_BOTH_EN` defined:
  - Each SCAN state checks windows for both players.
  - `winner` reports the matching player.
  - If both players match in the same scan cycle, the latched `cur_player` is reported.
- Not defined:
  - Only the latched `cur_player` is checked.
  - An opponent's four-in-a-row is ignored, giving NOTOVER or a draw.
  - `winner` always equals the latched player on a win.

## Test plan
- Only cell (col 3, row 0) occupied by player 0, `cur_player` = 0, `logic_go` held -> NOTOVER 12 cycles after E0, `is_draw` = 0.
- Row 0, cols 0..3 owned by player 1, `cur_player` = 1 -> OVER after E9, `winner` = 1, `is_draw` = 0.
- Down-right diagonal (0,5),(1,4),(2,3),(3,2) owned by player 0, `cur_player` = 0 -> OVER after E12, `winner` = 0.
- Full 42-cell board with no four-in-a-row -> OVER after E12, `is_draw` = 1, `winner` = 0.
- `logic_go` dropped during LOAD with `cnt` = 4 -> IDLE on the next edge, UNSURE, `busy` = 0. Re-asserting it runs a fresh full load (`rd_addr` sequence 0..6).
- `reset` asserted asynchronously in SCAN_V on a winning board -> outputs go to 0 immediately. After release with `logic_go` = 1, a full 9-cycle path to OVER.

Source files
------------

// File: rtl/win_checker.sv
// Connect Four win/draw detector: loads all 7 board columns into a shadow copy, then scans H/V/D1/D2 windows one state per cycle.
// Result 9..12 cycles after the start edge; level-held logic_go, abort on drop. Optional macro WIN_CHECK_BOTH_EN checks both players.
module win_checker (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_logic_go,
    input  logic       i_cur_player,
    input  logic [5:0] i_rd_onoff,
    input  logic [5:0] i_rd_player,
    output logic [2:0] o_rd_addr,
    output logic [1:0] o_logic_result,
    output logic       o_winner,
    output logic       o_is_draw,
    output logic       o_busy
);
    localparam int COLS = 7;
    localparam int ROWS = 6;
    localparam logic [1:0] RES_UNSURE  = 2'd0;
    localparam logic [1:0] RES_OVER    = 2'd1;
    localparam logic [1:0] RES_NOTOVER = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SCAN_H, S_SCAN_V, S_SCAN_D1, S_SCAN_D2, S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic              r_cur, w_cur_nxt;
    logic [2:0]        r_rd_addr, w_rd_addr_nxt;
    logic [1:0]        r_result, w_result_nxt;
    logic              r_winner, w_winner_nxt;
    logic              r_draw, w_draw_nxt;
    logic              r_busy, w_busy_nxt;
    logic [ROWS-1:0]   r_onoff  [COLS];
    logic [ROWS-1:0]   r_player [COLS];

    logic [COLS*ROWS-1:0] w_own0, w_own1, w_occ;
    logic [3:0]           w_dirs0, w_dirs1;
    logic                 w_hit0, w_hit1, w_hit, w_win_p, w_cap_en;

    // Returns {d2, d1, v, h}: any complete window of g in each direction; g index = col*ROWS + row.
    function automatic logic [3:0] scan_windows(input logic [COLS*ROWS-1:0] g);
        logic h, v, d1, d2;
        h = 1'b0; v = 1'b0; d1 = 1'b0; d2 = 1'b0;
        for (int c = 0; c < COLS - 3; c++)
            for (int r = 0; r < ROWS; r++)
                h = h | (g[c*ROWS+r] & g[(c+1)*ROWS+r] & g[(c+2)*ROWS+r] & g[(c+3)*ROWS+r]);
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS - 3; r++)
                v = v | (g[c*ROWS+r] & g[c*ROWS+r+1] & g[c*ROWS+r+2] & g[c*ROWS+r+3]);
        for (int c = 0; c < COLS - 3; c++)
            for (int r = 0; r < ROWS - 3; r++)
                d1 = d1 | (g[c*ROWS+r] & g[(c+1)*ROWS+r+1] & g[(c+2)*ROWS+r+2] & g[(c+3)*ROWS+r+3]);
        for (int c = 0; c < COLS - 3; c++)
            for (int r = 3; r < ROWS; r++)
                d2 = d2 | (g[c*ROWS+r] & g[(c+1)*ROWS+r-1] & g[(c+2)*ROWS+r-2] & g[(c+3)*ROWS+r-3]);
        return {d2, d1, v, h};
    endfunction

    always_comb begin
        w_own0 = '0;
        w_own1 = '0;
        w_occ  = '0;
        for (int c = 0; c < COLS; c++) begin
            w_own0[c*ROWS +: ROWS] = r_onoff[c] & ~r_player[c];
            w_own1[c*ROWS +: ROWS] = r_onoff[c] &  r_player[c];
            w_occ[c*ROWS +: ROWS]  = r_onoff[c];
        end
    end

    assign w_dirs0 = scan_windows(w_own0);
    assign w_dirs1 = scan_windows(w_own1);

    always_comb begin
        w_hit0 = 1'b0;
        w_hit1 = 1'b0;
        case (r_state)
            S_SCAN_H:  begin w_hit0 = w_dirs0[0]; w_hit1 = w_dirs1[0]; end
            S_SCAN_V:  begin w_hit0 = w_dirs0[1]; w_hit1 = w_dirs1[1]; end
            S_SCAN_D1: begin w_hit0 = w_dirs0[2]; w_hit1 = w_dirs1[2]; end
            S_SCAN_D2: begin w_hit0 = w_dirs0[3]; w_hit1 = w_dirs1[3]; end
            default:   ;
        endcase
    end

`ifdef WIN_CHECK_BOTH_EN
    assign w_hit   = w_hit0 | w_hit1;
    assign w_win_p = (w_hit0 & w_hit1) ? r_cur : w_hit1;
`else
    assign w_hit   = r_cur ? w_hit1 : w_hit0;
    assign w_win_p = r_cur;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cur_nxt     = r_cur;
        w_rd_addr_nxt = 3'd0;
        w_result_nxt  = r_result;
        w_winner_nxt  = r_winner;
        w_draw_nxt    = r_draw;
        w_cap_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_logic_go) begin
                    w_cur_nxt   = i_cur_player;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!i_logic_go) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    // Data for the address issued last cycle arrives now (1-cycle RAM).
                    w_cap_en      = (r_cnt != 3'd0);
                    w_cnt_nxt     = r_cnt + 3'd1;
                    w_rd_addr_nxt = (r_cnt < 3'd6) ? r_cnt + 3'd1 : 3'd0;
                    if (r_cnt == 3'd7)
                        w_state_nxt = S_SCAN_H;
                end
            end
            S_SCAN_H, S_SCAN_V, S_SCAN_D1, S_SCAN_D2: begin
                if (!i_logic_go) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hit) begin
                    w_result_nxt = RES_OVER;
                    w_winner_nxt = w_win_p;
                    w_draw_nxt   = 1'b0;
                    w_state_nxt  = S_DONE;
                end else if (r_state == S_SCAN_D2) begin
                    w_result_nxt = (&w_occ) ? RES_OVER : RES_NOTOVER;
                    w_draw_nxt   = &w_occ;
                    w_winner_nxt = 1'b0;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_state_nxt = state_t'(r_state + 3'd1);
                end
            end
            S_DONE: begin
                if (!i_logic_go) begin
                    w_result_nxt = RES_UNSURE;
                    w_winner_nxt = 1'b0;
                    w_draw_nxt   = 1'b0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_cur     <= 1'b0;
            r_rd_addr <= 3'd0;
            r_result  <= RES_UNSURE;
            r_winner  <= 1'b0;
            r_draw    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cur     <= w_cur_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_result  <= w_result_nxt;
            r_winner  <= w_winner_nxt;
            r_draw    <= w_draw_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int c = 0; c < COLS; c++) begin
                r_onoff[c]  <= '0;
                r_player[c] <= '0;
            end
        end else if (w_cap_en) begin
            for (int c = 0; c < COLS; c++) begin
                if (r_cnt == 3'(c + 1)) begin
                    r_onoff[c]  <= i_rd_onoff;
                    r_player[c] <= i_rd_player;
                end
            end
        end
    end

    assign o_rd_addr      = r_rd_addr;
    assign o_logic_result = r_result;
    assign o_winner       = r_winner;
    assign o_is_draw      = r_draw;
    assign o_busy         = r_busy;
endmodule

// File: tb/tb_win_checker.sv
// Bench for win_checker: board RAM model with 1-cycle read, window-search reference model, per-cycle output compare.
`timescale 1ns/1ps
module tb_win_checker;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       go;
    logic       cur;
    logic [5:0] ram_on, ram_pl;
    logic [2:0] o_rd_addr;
    logic [1:0] o_logic_result;
    logic       o_winner, o_is_draw, o_busy;

    logic [5:0] mem_on [7];
    logic [5:0] mem_pl [7];

    int   n_checks = 0;
    int   n_err    = 0;
    logic chk_en   = 1'b0;

    logic [2:0] exp_addr;
    logic [1:0] exp_res;
    logic       exp_win, exp_draw, exp_busy;

    always #5 clk = ~clk;

    win_checker dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_logic_go     (go),
        .i_cur_player   (cur),
        .i_rd_onoff     (ram_on),
        .i_rd_player    (ram_pl),
        .o_rd_addr      (o_rd_addr),
        .o_logic_result (o_logic_result),
        .o_winner       (o_winner),
        .o_is_draw      (o_is_draw),
        .o_busy         (o_busy)
    );

    // Board RAMs: address seen at an edge returns data in the following cycle.
    always @(posedge clk) begin
        ram_on <= (o_rd_addr <= 3'd6) ? mem_on[o_rd_addr] : 6'h00;
        ram_pl <= (o_rd_addr <= 3'd6) ? mem_pl[o_rd_addr] : 6'h00;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_addr", 8'(o_rd_addr), 8'(exp_addr));
            check("result",  8'(o_logic_result), 8'(exp_res));
            check("winner",  8'(o_winner), 8'(exp_win));
            check("is_draw", 8'(o_is_draw), 8'(exp_draw));
            check("busy",    8'(o_busy), 8'(exp_busy));
        end
    end

    function automatic bit owns(int c, int r, bit p);
        return mem_on[c][r] && (mem_pl[c][r] == p);
    endfunction

    // Direction d: 0 horizontal, 1 vertical, 2 up-right, 3 down-right.
    function automatic bit dir_win(int d, bit p);
        int dc, dr, cc, rr;
        bit all4;
        dc = (d == 1) ? 0 : 1;
        dr = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                all4 = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    cc = c + i * dc;
                    rr = r + i * dr;
                    if (cc < 0 || cc > 6 || rr < 0 || rr > 5) all4 = 1'b0;
                    else if (!owns(cc, rr, p)) all4 = 1'b0;
                end
                if (all4) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // dec = edge number (counted from the start edge) after which the result is visible.
    task automatic model(input bit p, output logic [1:0] res, output bit win, output bit draw, output int dec);
        bit full, h0, h1, hit, wp;
        full = 1'b1;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                if (!mem_on[c][r]) full = 1'b0;
        res = 2'd2; win = 1'b0; draw = 1'b0; dec = 12;
        for (int d = 0; d < 4; d++) begin
            h0 = dir_win(d, 1'b0);
            h1 = dir_win(d, 1'b1);
`ifdef WIN_CHECK_BOTH_EN
            hit = h0 | h1;
            wp  = (h0 && h1) ? p : h1;
`else
            hit = p ? h1 : h0;
            wp  = p;
`endif
            if (hit) begin
                res = 2'd1; win = wp; dec = 9 + d;
                return;
            end
        end
        if (full) begin
            res = 2'd1; draw = 1'b1;
        end
    endtask

    task automatic set_idle();
        exp_addr = 3'd0; exp_res = 2'd0; exp_win = 1'b0; exp_draw = 1'b0; exp_busy = 1'b0;
    endtask

    task automatic set_exp(input int n, input int dec, input logic [1:0] res, input bit win, input bit draw);
        exp_addr = (n <= 6) ? 3'(n) : 3'd0;
        if (n < dec) begin
            exp_busy = 1'b1; exp_res = 2'd0; exp_win = 1'b0; exp_draw = 1'b0;
        end else begin
            exp_busy = 1'b0; exp_res = res; exp_win = win; exp_draw = draw;
        end
    endtask

    task automatic clear_board();
        for (int c = 0; c < 7; c++) begin
            mem_on[c] = 6'h00;
            mem_pl[c] = 6'h00;
        end
    endtask

    // Entered #2 after an edge with the DUT idle; the next edge is the start edge.
    task automatic run_case(input bit p, input int abort_at, input int hold);
        logic [1:0] res;
        bit win, draw;
        int dec, last;
        model(p, res, win, draw, dec);
        last = (abort_at >= 0 && abort_at < dec) ? abort_at : dec + hold;
        cur = p;
        go  = 1'b1;
        for (int n = 0; n <= last; n++) begin
            @(posedge clk); #2;
            set_exp(n, dec, res, win, draw);
        end
        go = 1'b0;
        @(posedge clk); #2; set_idle();
        @(posedge clk); #2; set_idle();
    endtask

    task automatic pin_model(input string name, input bit p, input logic [1:0] e_res,
                             input bit e_win, input bit e_draw, input int e_dec);
        logic [1:0] res;
        bit win, draw;
        int dec;
        model(p, res, win, draw, dec);
        check({name, "_res"},  8'(res),  8'(e_res));
        check({name, "_win"},  8'(win),  8'(e_win));
        check({name, "_draw"}, 8'(draw), 8'(e_draw));
        check({name, "_dec"},  8'(dec),  8'(e_dec));
    endtask

    initial begin
        logic [1:0] pres;
        bit pwin, pdraw;
        int pdec, dens, ab;
        rst_n = 1'b0; go = 1'b0; cur = 1'b0;
        clear_board();
        set_idle();
        #1;
        check("rst_addr",   8'(o_rd_addr), 8'd0);
        check("rst_result", 8'(o_logic_result), 8'd0);
        check("rst_busy",   8'(o_busy), 8'd0);
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #2;

        // Single piece: nothing decided.
        clear_board();
        mem_on[3] = 6'b000001;
        pin_model("np", 1'b0, 2'd2, 1'b0, 1'b0, 12);
        run_case(1'b0, -1, 2);

        // Horizontal bottom row for player 1.
        clear_board();
        for (int c = 0; c < 4; c++) begin mem_on[c][0] = 1'b1; mem_pl[c][0] = 1'b1; end
        pin_model("hwin", 1'b1, 2'd1, 1'b1, 1'b0, 9);
        run_case(1'b1, -1, 1);

        // Down-right diagonal for player 0.
        clear_board();
        for (int i = 0; i < 4; i++) mem_on[i][5-i] = 1'b1;
        pin_model("d2win", 1'b0, 2'd1, 1'b0, 1'b0, 12);
        run_case(1'b0, -1, 1);

        // Full board with no four-in-a-row.
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) begin
                mem_on[c][r] = 1'b1;
                mem_pl[c][r] = 1'(((c >> 1) + r) & 1);
            end
        pin_model("draw", 1'b1, 2'd1, 1'b0, 1'b1, 12);
        run_case(1'b1, -1, 2);

        // Abort during LOAD at cnt = 4, then a fresh full run.
        clear_board();
        for (int c = 0; c < 4; c++) begin mem_on[c][0] = 1'b1; mem_pl[c][0] = 1'b1; end
        run_case(1'b1, 4, 0);
        run_case(1'b1, -1, 0);

        // Reset asserted in SCAN_V on a vertical-win board.
        clear_board();
        mem_on[2] = 6'b001111; mem_pl[2] = 6'b001111;
        pin_model("vwin", 1'b1, 2'd1, 1'b1, 1'b0, 10);
        model(1'b1, pres, pwin, pdraw, pdec);
        cur = 1'b1; go = 1'b1;
        for (int n = 0; n <= 9; n++) begin
            @(posedge clk); #2;
            set_exp(n, pdec, pres, pwin, pdraw);
        end
        #1; chk_en = 1'b0; rst_n = 1'b0;
        #1;
        check("arst_result", 8'(o_logic_result), 8'd0);
        check("arst_winner", 8'(o_winner), 8'd0);
        check("arst_draw",   8'(o_is_draw), 8'd0);
        check("arst_busy",   8'(o_busy), 8'd0);
        check("arst_addr",   8'(o_rd_addr), 8'd0);
        set_idle(); chk_en = 1'b1;
        clear_board();
        for (int c = 0; c < 4; c++) begin mem_on[c][0] = 1'b1; mem_pl[c][0] = 1'b1; end
        pin_model("hwin2", 1'b1, 2'd1, 1'b1, 1'b0, 9);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_case(1'b1, -1, 1);

        // Randomized boards, players, hold times and aborts.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(3))
                0: dens = 50;
                1: dens = 75;
                2: dens = 90;
                default: dens = 100;
            endcase
            for (int c = 0; c < 7; c++)
                for (int r = 0; r < 6; r++) begin
                    mem_on[c][r] = ($urandom_range(99) < dens);
                    mem_pl[c][r] = 1'($urandom_range(1));
                end
            ab = ($urandom_range(4) == 0) ? int'($urandom_range(11)) : -1;
            run_case(1'($urandom_range(1)), ab, int'($urandom_range(2)));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
